// File: rtl/rv32_uart_tx.sv
// rv32_uart_tx: 8N1 UART transmitter fed by a byte push port.
// Bytes are buffered, then serialised LSB first: one start bit, eight data bits, one stop bit.
// Each bit lasts CLKS_PER_BIT clock cycles.
// Build option RV32_UART_TX_FIFO_EN selects the buffer:
//   defined   -> FIFO_DEPTH-entry FIFO
//   undefined -> single-byte holding register (capacity 1)
module rv32_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 1250,
    parameter int unsigned FIFO_DEPTH   = 16
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       wr_en_in,
    input  logic [7:0] data_in,
    output logic       ready_out,
    output logic       tx_out,
    output logic       busy_out,
    output logic       overflow_out
);

    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef RV32_UART_TX_FIFO_EN
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] CAP = CNT_W'(FIFO_DEPTH);
`else
    localparam logic [CNT_W-1:0] CAP = CNT_W'(1);
`endif
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state_q, state_d;
    logic [15:0]      baud_q, baud_d;
    logic [2:0]       bit_idx_q, bit_idx_d;
    logic [7:0]       shift_q, shift_d;
    logic             tx_q, tx_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push;
    logic             pop;
    logic [7:0]       head_data;

    // A pop happens whenever the serialiser is idle and a byte is waiting.
    // A push at full is still taken when that same cycle frees a slot.
    assign pop          = (state_q == IDLE) && (count_q != '0);
    assign ready_out    = (count_q < CAP) || pop;
    assign push         = wr_en_in && ready_out;
    assign busy_out     = (state_q != IDLE) || (count_q != '0);
    assign tx_out       = tx_q;
    assign overflow_out = overflow_q;

`ifdef RV32_UART_TX_FIFO_EN
    logic [7:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;

    // Pointers wrap naturally because FIFO_DEPTH is a power of two.
    assign wr_ptr_d  = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    assign rd_ptr_d  = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    assign head_data = mem_q[rd_ptr_q];

    // FIFO storage: data only, so it is not reset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    // FIFO pointer registers.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end
`else
    logic [7:0] hold_q;

    assign head_data = hold_q;

    // Holding register.
    // A new byte may overwrite it on the same edge that the old byte is popped into the shifter.
    always_ff @(posedge clk) begin
        if (push) begin
            hold_q <= data_in;
        end
    end
`endif

    // Buffered-byte count: up on push, down on pop, unchanged when both occur.
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // A push request that is not accepted latches the overflow flag until reset.
    assign overflow_d = overflow_q || (wr_en_in && !ready_out);

    // Serialiser next state.
    // The baud counter restarts at every bit boundary.
    // tx is registered, so the new line level appears on the same edge as the state change.
    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        case (state_q)
            IDLE: begin
                baud_d    = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                if (pop) begin
                    shift_d = head_data;
                    tx_d    = 1'b0;
                    state_d = START;
                end
            end
            START: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    tx_d      = shift_q[0];
                    shift_d   = {1'b0, shift_q[7:1]};
                    state_d   = DATA;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d = '0;
                    if (bit_idx_q == 3'd7) begin
                        bit_idx_d = '0;
                        tx_d      = 1'b1;
                        state_d   = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        tx_d      = shift_q[0];
                        shift_d   = {1'b0, shift_q[7:1]};
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_q == BAUD_LAST) begin
                    baud_d  = '0;
                    tx_d    = 1'b1;
                    state_d = IDLE;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                baud_d    = '0;
                bit_idx_d = '0;
                tx_d      = 1'b1;
                state_d   = IDLE;
            end
        endcase
    end

    // Control registers.
    // Reset aborts any frame, drops buffered bytes and ignores a concurrent push.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            baud_q     <= '0;
            bit_idx_q  <= '0;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            count_q    <= count_d;
        end
    end

    // Shift register: data only, so it is not reset.
    always_ff @(posedge clk) begin
        shift_q <= shift_d;
    end

endmodule

// File: tb/tb_rv32_uart_tx.sv
// tb_rv32_uart_tx: directed bench for rv32_uart_tx with CLKS_PER_BIT=4 and FIFO_DEPTH=4.
// It works in either build; the buffer capacity follows RV32_UART_TX_FIFO_EN.
// tx_out is recorded every cycle into wave[].
// Each recorded frame is compared with a waveform built from the byte value.
module tb_rv32_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
`ifdef RV32_UART_TX_FIFO_EN
    localparam int CAP = DEPTH;
`else
    localparam int CAP = 1;
`endif
    localparam int FRAME = 10 * CPB;
    localparam int SLOT  = FRAME + 1;

    logic       clk      = 1'b0;
    logic       reset_n  = 1'b0;
    logic       wr_en_in = 1'b0;
    logic [7:0] data_in  = 8'h00;
    logic       ready_out;
    logic       tx_out;
    logic       busy_out;
    logic       overflow_out;

    rv32_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .wr_en_in    (wr_en_in),
        .data_in     (data_in),
        .ready_out   (ready_out),
        .tx_out      (tx_out),
        .busy_out    (busy_out),
        .overflow_out(overflow_out)
    );

    always #5 clk = ~clk;

    // wave[k] holds tx_out as it stood after the k-th rising edge, sampled at the falling edge.
    logic wave [0:8191];
    int   ncyc = 0;

    always @(negedge clk) begin
        if (ncyc < 8192) wave[ncyc] = tx_out;
        ncyc++;
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_reset();
        reset_n  = 1'b0;
        wr_en_in = 1'b0;
        tick(2);
        reset_n  = 1'b1;
    endtask

    task automatic push(input logic [7:0] b);
        wr_en_in = 1'b1;
        data_in  = b;
        tick();
        wr_en_in = 1'b0;
    endtask

    // Expected line for one frame plus the following cycle:
    // start 0, data bits LSB first, stop 1, then one idle 1.
    function automatic logic [40:0] frame_exp(input logic [7:0] b);
        logic [40:0] v;
        int slot;
        for (int i = 0; i < SLOT; i++) begin
            slot = i / CPB;
            if (slot == 0)      v[i] = 1'b0;
            else if (slot <= 8) v[i] = b[slot-1];
            else                v[i] = 1'b1;
        end
        return v;
    endfunction

    function automatic logic [40:0] frame_obs(input int idx);
        logic [40:0] v;
        for (int i = 0; i < SLOT; i++) v[i] = wave[idx+i];
        return v;
    endfunction

    int a;
    int s;
    int r;
    int lat;
    logic [49:0] quiet;

    initial begin
        // Reset state
        do_reset();
        check("rst_tx", tx_out, 1);
        check("rst_ready", ready_out, 1);
        check("rst_busy", busy_out, 0);
        check("rst_ovf", overflow_out, 0);

        // Single byte 0xA5 from idle
        push(8'hA5);
        a = ncyc;
        check("t1_busy_at_accept", busy_out, 1);
        check("t1_tx_at_accept", tx_out, 1);
        lat = 0;
        while (tx_out !== 1'b0 && lat < 10) begin
            tick();
            lat++;
        end
        check("t1_start_latency", lat, 1);
        tick(FRAME - 1);
        check("t1_busy_before_end", busy_out, 1);
        tick();
        check("t1_busy_end", busy_out, 0);
        check("t1_tx_end", tx_out, 1);
        tick(2);
        check("t1_frame", frame_obs(a + 1), frame_exp(8'hA5));

        // Three back-to-back pushes
        do_reset();
        push(8'h01);
        a = ncyc;
        push(8'h02);
        push(8'h03);
        check("t2_ovf", overflow_out, (CAP > 1) ? 0 : 1);
        tick(3 * SLOT + 5);
        check("t2_frame0", frame_obs(a + 1), frame_exp(8'h01));
        check("t2_frame1", frame_obs(a + 1 + SLOT), frame_exp(8'h02));
        check("t2_frame2", frame_obs(a + 1 + 2 * SLOT), (CAP > 1) ? frame_exp(8'h03) : {41{1'b1}});
        check("t2_busy_end", busy_out, 0);

        // Six pushes while idle: buffer fills, the extra pushes are dropped
        do_reset();
        push(8'h10);
        a = ncyc;
        for (int k = 1; k < 5; k++) push(8'h10 + 8'(k));
        check("t3_ready_full", ready_out, 0);
        check("t3_ovf_before", overflow_out, (CAP > 1) ? 0 : 1);
        push(8'h15);
        check("t3_ovf_after", overflow_out, 1);
        tick(6 * SLOT + 5);
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_frame%0d", k), frame_obs(a + 1 + k * SLOT),
                  (k <= CAP) ? frame_exp(8'h10 + 8'(k)) : {41{1'b1}});
        end
        check("t3_busy_end", busy_out, 0);

        // Push at full coinciding with a pop
        do_reset();
        push(8'h20);
        a = ncyc;
        s = a + 1;
        tick();
        for (int k = 0; k < CAP; k++) push(8'h21 + 8'(k));
        tick(39 - CAP);
        check("t4_ready_full_stop", ready_out, 0);
        tick();
        check("t4_ready_full_pop", ready_out, 1);
        check("t4_busy_idle_cycle", busy_out, 1);
        push(8'h21 + 8'(CAP));
        check("t4_ovf", overflow_out, 0);
        tick((CAP + 2) * SLOT + 5);
        for (int k = 0; k < CAP + 2; k++) begin
            check($sformatf("t4_frame%0d", k), frame_obs(s + k * SLOT), frame_exp(8'h20 + 8'(k)));
        end
        check("t4_ovf_end", overflow_out, 0);

        // Reset during data bit 3, with bytes pending and the overflow flag set
        do_reset();
        push(8'hA5);
        tick();
        for (int k = 0; k <= CAP; k++) push(8'h30 + 8'(k));
        check("t5_ovf_set", overflow_out, 1);
        tick(15 - CAP);
        check("t5_tx_bit3", tx_out, 0);
        check("t5_busy_bit3", busy_out, 1);
        reset_n  = 1'b0;
        wr_en_in = 1'b1;
        data_in  = 8'hFF;
        r = ncyc;
        tick();
        check("t5_tx_after_rst", tx_out, 1);
        check("t5_busy_after_rst", busy_out, 0);
        check("t5_ovf_after_rst", overflow_out, 0);
        check("t5_ready_after_rst", ready_out, 1);
        reset_n  = 1'b1;
        wr_en_in = 1'b0;
        tick(60);
        for (int i = 0; i < 50; i++) quiet[i] = wave[r+1+i];
        check("t5_line_quiet", quiet, {50{1'b1}});
        check("t5_busy_quiet", busy_out, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

endmodule
